// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle write forwarding; writes
// and reserves update on the rising clock edge; reset clears all state.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rbusy,
  input  logic [NUM_WR-1:0]        i_wen,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic [NUM_WR*DATA_W-1:0] i_wdata,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;

  logic [ADDR_W-1:0] rd_idx [NUM_RD];
  logic [ADDR_W-1:0] wr_idx [NUM_WR];
  logic [DATA_W-1:0] wr_dat [NUM_WR];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign rd_idx[k] = i_raddr[k*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign wr_idx[j] = i_waddr[j*ADDR_W +: ADDR_W];
    assign wr_dat[j] = i_wdata[j*DATA_W +: DATA_W];
  end

  // Next state: writes in ascending port order so the highest port wins,
  // then the reserve so a same-index reserve overrides the write's release.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (i_wen[j]) begin
        regs_d[wr_idx[j]] = wr_dat[j];
        busy_d[wr_idx[j]] = 1'b0;
      end
    end
    if (i_rsv_en) begin
      busy_d[i_rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  // Forwarding is suppressed during reset so reads stay at zero.
  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      o_rdata[k*DATA_W +: DATA_W] = regs_q[rd_idx[k]];
      o_rbusy[k]                  = busy_q[rd_idx[k]];
      if ((BYPASS != 0) && i_rst_n) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (i_wen[j] && (wr_idx[j] == rd_idx[k])) begin
            o_rdata[k*DATA_W +: DATA_W] = wr_dat[j];
            o_rbusy[k]                  = i_rsv_en && (i_rsv_addr == rd_idx[k]);
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_idx[k] == '0)) begin
        o_rdata[k*DATA_W +: DATA_W] = '0;
        o_rbusy[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance without forwarding, one with,
// both driven from the same stimulus.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [63:0] rdata_nb, rdata_b;
  logic [1:0]  rbusy_nb, rbusy_b;

  int vecs = 0;
  int errs = 0;

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_nb), .o_rbusy(rbusy_nb),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr)
  );

  regfile_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wen      = 2'b00;
    waddr    = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    raddr = {5'd4, 5'd3};
    #1;
    vecs++;
    if ({rdata_nb, rdata_b} !== 128'h0 || {rbusy_nb, rbusy_b} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_initial: data nb=%h b=%h busy nb=%b b=%b expected 0", rdata_nb,
               rdata_b, rbusy_nb, rbusy_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Load x3 and reserve x4 so the mid-run reset has something to clear.
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h0000_00AB};
    rsv_en = 1'b1; rsv_addr = 5'd4;
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rdata_nb[31:0] !== 32'h0000_00AB || rbusy_nb[1] !== 1'b1) begin
      errs++;
      $display("FAIL reset_preload: x3=%h busy4=%b expected 000000ab 1", rdata_nb[31:0],
               rbusy_nb[1]);
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({rdata_nb, rdata_b} !== 128'h0 || {rbusy_nb, rbusy_b} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_async: data nb=%h b=%h busy nb=%b b=%b expected 0", rdata_nb,
               rdata_b, rbusy_nb, rbusy_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if ({rdata_nb, rdata_b} !== 128'h0 || {rbusy_nb, rbusy_b} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_release: data nb=%h b=%h busy nb=%b b=%b expected 0", rdata_nb,
               rdata_b, rbusy_nb, rbusy_b);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    raddr = {5'd0, 5'd5};
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD_BEEF};
    #1;
    vecs++;
    if (rdata_nb[31:0] !== 32'h0) begin
      errs++;
      $display("FAIL nobypass_same_cycle: got %h expected 00000000", rdata_nb[31:0]);
    end
    vecs++;
    if (rdata_b[31:0] !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rdata_b[31:0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rdata_nb[31:0] !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL nobypass_next_cycle: got %h expected deadbeef", rdata_nb[31:0]);
    end
    vecs++;
    if (rdata_b[31:0] !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL bypass_next_cycle: got %h expected deadbeef", rdata_b[31:0]);
    end
  endtask

  task automatic test_write_conflict();
    @(negedge clk);
    raddr = {5'd7, 5'd7};
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h0000_0022, 32'h0000_0011};
    #1;
    vecs++;
    if (rdata_b !== {32'h22, 32'h22}) begin
      errs++;
      $display("FAIL conflict_bypass: got %h expected 0000002200000022", rdata_b);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rdata_nb !== {32'h22, 32'h22} || rdata_b !== {32'h22, 32'h22}) begin
      errs++;
      $display("FAIL conflict_stored: nb=%h b=%h expected 0000002200000022", rdata_nb, rdata_b);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    raddr = {5'd9, 5'd0};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    vecs++;
    if (rbusy_nb[1] !== 1'b0) begin
      errs++;
      $display("FAIL rsv_before_edge: busy=%b expected 0", rbusy_nb[1]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rbusy_nb[1] !== 1'b1 || rbusy_b[1] !== 1'b1) begin
      errs++;
      $display("FAIL rsv_after_edge: busy nb=%b b=%b expected 1 1", rbusy_nb[1], rbusy_b[1]);
    end
    @(negedge clk);
    wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h0000_0033, 32'h0};
    #1;
    vecs++;
    if (rbusy_b[1] !== 1'b0 || rdata_b[63:32] !== 32'h33 || rbusy_nb[1] !== 1'b1) begin
      errs++;
      $display("FAIL release_same_cycle: b busy=%b data=%h nb busy=%b expected 0 00000033 1",
               rbusy_b[1], rdata_b[63:32], rbusy_nb[1]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rbusy_nb[1] !== 1'b0 || rdata_nb[63:32] !== 32'h33) begin
      errs++;
      $display("FAIL release_after_edge: busy=%b data=%h expected 0 00000033", rbusy_nb[1],
               rdata_nb[63:32]);
    end
    @(negedge clk);
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h0000_0044};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rbusy_nb[1] !== 1'b1 || rdata_nb[63:32] !== 32'h44 ||
        rbusy_b[1] !== 1'b1 || rdata_b[63:32] !== 32'h44) begin
      errs++;
      $display("FAIL rsv_and_write: nb busy=%b data=%h b busy=%b data=%h expected 1 00000044",
               rbusy_nb[1], rdata_nb[63:32], rbusy_b[1], rdata_b[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    raddr = {5'd0, 5'd0};
    wen = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    vecs++;
    if (rdata_b !== 64'h0 || rbusy_b !== 2'b00) begin
      errs++;
      $display("FAIL zero_bypass: data=%h busy=%b expected 0 00", rdata_b, rbusy_b);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rdata_nb !== 64'h0 || rbusy_nb !== 2'b00 || rdata_b !== 64'h0 || rbusy_b !== 2'b00) begin
      errs++;
      $display("FAIL zero_stored: nb data=%h busy=%b b data=%h busy=%b expected 0", rdata_nb,
               rbusy_nb, rdata_b, rbusy_b);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    raddr = {5'd13, 5'd12};
    wen = 2'b11; waddr = {5'd13, 5'd12}; wdata = {32'hBBBB_0002, 32'hAAAA_0001};
    @(posedge clk); #1;
    wen = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'h0, 32'h1234_5678};
    #1;
    vecs++;
    if (rdata_nb !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
      errs++;
      $display("FAIL dual_write: got %h expected bbbb0002aaaa0001", rdata_nb);
    end
    vecs++;
    if (rdata_b !== {32'hBBBB_0002, 32'h1234_5678}) begin
      errs++;
      $display("FAIL b2b_bypass: got %h expected bbbb000212345678", rdata_b);
    end
    @(posedge clk); #1;
    idle();
    #1;
    vecs++;
    if (rdata_nb !== {32'hBBBB_0002, 32'h1234_5678}) begin
      errs++;
      $display("FAIL b2b_stored: got %h expected bbbb000212345678", rdata_nb);
    end
    // Earlier contents must survive unrelated traffic.
    raddr = {5'd7, 5'd5};
    #1;
    vecs++;
    if (rdata_nb !== {32'h22, 32'hDEAD_BEEF}) begin
      errs++;
      $display("FAIL retain: got %h expected 00000022deadbeef", rdata_nb);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_conflict();
    test_scoreboard();
    test_zero_reg();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
